// File: rtl/uram_result_drain.sv
// uram_result_drain: credit-based sequential reader of the output URAM, delivering words in address order on a valid/ready stream.
// Optional stall counter (stall_cnt output) is built when URAM_DRAIN_STALL_CNT_EN is defined.
//
//  state   | meaning
//  --------+-------------------------------------------------------------
//  S_IDLE  | waiting for start
//  S_ISSUE | issuing reads whenever credit is available
//  S_WAIT  | all reads issued, draining buffer until the last word leaves
//  S_FIN   | one-cycle done pulse, then back to idle

module uram_result_drain #(
    parameter int URAM_A_W = 23,
    parameter int URAM_D_W = 72,
    parameter int RD_LAT   = 2,
    parameter int BUF_D    = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [URAM_A_W-1:0] base_addr,
    input  logic [URAM_A_W-1:0] num_words,
    output logic                busy,
    output logic                done,
    output logic [URAM_A_W-1:0] uram_rd_addr,
    output logic                uram_rd_en,
    input  logic [URAM_D_W-1:0] uram_rd_data,
    output logic [URAM_D_W-1:0] m_data,
    output logic                m_valid,
    input  logic                m_ready,
    output logic                m_last
`ifdef URAM_DRAIN_STALL_CNT_EN
    ,
    output logic [31:0]         stall_cnt
`endif
);

    localparam int PTR_W = $clog2(BUF_D);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0]    BUF_FULL = CNT_W'(BUF_D);
    localparam logic [CNT_W-1:0]    C_ONE    = CNT_W'(1);
    localparam logic [PTR_W-1:0]    P_ONE    = PTR_W'(1);
    localparam logic [URAM_A_W-1:0] A_ONE    = URAM_A_W'(1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_FIN} state_t;

    state_t              state;
    logic [URAM_A_W-1:0] base_r;
    logic [URAM_A_W-1:0] num_r;
    logic [URAM_A_W-1:0] issued_cnt;
    logic [URAM_A_W-1:0] load_cnt;
    logic [RD_LAT-1:0]   vld_pipe;
    logic [RD_LAT:0]     pipe_ext;
    logic [CNT_W-1:0]    used;
    logic [CNT_W-1:0]    fifo_cnt;
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [URAM_D_W-1:0] mem [BUF_D];

    logic push;
    logic pop_out;
    logic out_free;
    logic fifo_rd;
    logic fifo_wr;
    logic bypass;
    logic load;
    logic issue;
    logic last_issue;

    // used = words in buffer + output register + reads in flight; pops of this cycle are not credited yet.
    always_comb begin
        pipe_ext   = {vld_pipe, uram_rd_en};
        push       = pipe_ext[RD_LAT];
        pop_out    = m_valid & m_ready;
        out_free   = !m_valid | m_ready;
        fifo_rd    = out_free && (fifo_cnt != '0);
        bypass     = out_free && (fifo_cnt == '0) && push;
        load       = fifo_rd | bypass;
        fifo_wr    = push & !bypass;
        issue      = (state == S_ISSUE) && (used < BUF_FULL);
        last_issue = issue && (issued_cnt == num_r - A_ONE);
    end

    always_ff @(posedge clk) begin
        if (fifo_wr) mem[wr_ptr] <= uram_rd_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            uram_rd_en   <= 1'b0;
            uram_rd_addr <= '0;
            vld_pipe     <= '0;
            base_r       <= '0;
            num_r        <= '0;
            issued_cnt   <= '0;
            load_cnt     <= '0;
            used         <= '0;
            fifo_cnt     <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            m_data       <= '0;
            m_valid      <= 1'b0;
            m_last       <= 1'b0;
        end else begin
            vld_pipe   <= pipe_ext[RD_LAT-1:0];
            uram_rd_en <= issue;
            if (issue) begin
                uram_rd_addr <= base_r + issued_cnt;
                issued_cnt   <= issued_cnt + A_ONE;
            end

            case ({issue, pop_out})
                2'b10:   used <= used + C_ONE;
                2'b01:   used <= used - C_ONE;
                default: ;
            endcase

            if (fifo_wr) wr_ptr <= wr_ptr + P_ONE;
            if (fifo_rd) rd_ptr <= rd_ptr + P_ONE;
            case ({fifo_wr, fifo_rd})
                2'b10:   fifo_cnt <= fifo_cnt + C_ONE;
                2'b01:   fifo_cnt <= fifo_cnt - C_ONE;
                default: ;
            endcase

            // Output register refills from the buffer head, or straight from the URAM when the buffer is empty.
            if (out_free) begin
                m_valid <= load;
                m_last  <= load && (load_cnt == num_r - A_ONE);
                if (load) begin
                    m_data   <= fifo_rd ? mem[rd_ptr] : uram_rd_data;
                    load_cnt <= load_cnt + A_ONE;
                end
            end

            case (state)
                S_IDLE: begin
                    if (start) begin
                        base_r     <= base_addr;
                        num_r      <= num_words;
                        issued_cnt <= '0;
                        load_cnt   <= '0;
                        busy       <= 1'b1;
                        if (num_words == '0) begin
                            state <= S_FIN;
                            done  <= 1'b1;
                        end else begin
                            state <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    if (last_issue) state <= S_WAIT;
                end
                S_WAIT: begin
                    if (pop_out && m_last) begin
                        state <= S_FIN;
                        done  <= 1'b1;
                    end
                end
                S_FIN: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) assert (!(fifo_wr && !fifo_rd && (fifo_cnt == BUF_FULL)));
    end

`ifdef URAM_DRAIN_STALL_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if ((state == S_IDLE) && start) begin
            stall_cnt <= '0;
        end else if (busy && m_valid && !m_ready && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_uram_result_drain.sv
// Bench for uram_result_drain: URAM latency model, queue-based stream model, per-cycle compare and literal pins.
module tb_uram_result_drain;

    localparam int AW     = 23;
    localparam int DW     = 72;
    localparam int RD_LAT = 2;
    localparam int BUF_D  = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW-1:0] num_words = '0;
    logic          m_ready = 1'b1;
    logic          busy, done, uram_rd_en, m_valid, m_last;
    logic [AW-1:0] uram_rd_addr;
    logic [DW-1:0] uram_rd_data, m_data;
`ifdef URAM_DRAIN_STALL_CNT_EN
    logic [31:0]   stall_cnt;
`endif

    uram_result_drain #(.URAM_A_W(AW), .URAM_D_W(DW), .RD_LAT(RD_LAT), .BUF_D(BUF_D)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .num_words(num_words),
        .busy(busy), .done(done), .uram_rd_addr(uram_rd_addr), .uram_rd_en(uram_rd_en),
        .uram_rd_data(uram_rd_data), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .m_last(m_last)
`ifdef URAM_DRAIN_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] data_of(input logic [AW-1:0] a);
        return {a ^ 23'h155555, 26'h0, a};
    endfunction

    // URAM: data for the address presented RD_LAT cycles ago, returned every cycle.
    logic [AW-1:0] hist_addr [RD_LAT];
    always @(posedge clk) begin
        for (int i = RD_LAT - 1; i > 0; i--) hist_addr[i] <= hist_addr[i-1];
        hist_addr[0] <= uram_rd_addr;
    end
    assign uram_rd_data = data_of(hist_addr[RD_LAT-1]);

    int ready_mode = 0;
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       m_ready = 1'b1;
            1:       m_ready = ($urandom_range(0, 99) < 30);
            default: m_ready = 1'b0;
        endcase
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic fail(input string nm);
        checks++;
        failures++;
        $display("FAIL %s", nm);
    endtask

    // Model state
    logic [DW-1:0] exp_data_q [$];
    logic [AW-1:0] exp_addr_q [$];
    logic [AW-1:0] log_rd [$];
    logic [AW-1:0] log_word [$];
    logic [AW-1:0] last_word;
    int  exp_idx = 0, exp_num = 0;
    bit  model_busy = 0, done_next = 0;
    int  issued_total = 0, xfer_total = 0, xfer_lag = 0;
    int  done_seen = 0, start_cyc = 0, done_cyc = 0, cyc = 0;
    bit  prev_stall = 0;
    logic [DW-1:0] prev_data = '0;
    logic [31:0]   stall_model = '0;

    always @(negedge clk) begin
        bit was_done;
        bit last_xfer;
        cyc++;
        if (!rst) begin
            exp_data_q.delete();
            exp_addr_q.delete();
            model_busy = 0; done_next = 0; prev_stall = 0; stall_model = '0;
            issued_total = 0; xfer_total = 0; xfer_lag = 0;
        end else begin
            was_done  = done_next;
            last_xfer = 0;
            chk("busy", DW'(busy), DW'(model_busy));
            chk("done", DW'(done), DW'(done_next));
            if (uram_rd_en) begin
                if (exp_addr_q.size() == 0) fail("rd_en_unexpected");
                else begin
                    chk("rd_addr", DW'(uram_rd_addr), DW'(exp_addr_q.pop_front()));
                    log_rd.push_back(uram_rd_addr);
                end
                issued_total++;
                chk("credit", DW'(issued_total - xfer_lag <= BUF_D), DW'(1));
            end
            if (prev_stall) begin
                chk("hold_valid", DW'(m_valid), DW'(1));
                chk("hold_data", m_data, prev_data);
            end
`ifdef URAM_DRAIN_STALL_CNT_EN
            chk("stall_cnt", DW'(stall_cnt), DW'(stall_model));
`endif
            xfer_lag = xfer_total;
            if (m_valid && m_ready) begin
                if (exp_data_q.size() == 0) fail("m_xfer_unexpected");
                else begin
                    chk("m_data", m_data, exp_data_q.pop_front());
                    chk("m_last", DW'(m_last), DW'(exp_idx == exp_num - 1));
                    log_word.push_back(m_data[AW-1:0]);
                    if (m_last) last_word = m_data[AW-1:0];
                    exp_idx++;
                    xfer_total++;
                    if (exp_idx == exp_num) last_xfer = 1;
                end
            end
            if (model_busy && m_valid && !m_ready && stall_model != 32'hFFFF_FFFF) stall_model++;
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            if (start && !model_busy) begin
                model_busy = 1;
                exp_num = int'(num_words);
                exp_idx = 0;
                exp_data_q.delete();
                exp_addr_q.delete();
                for (int i = 0; i < exp_num; i++) begin
                    logic [AW-1:0] a;
                    a = base_addr + AW'(i);
                    exp_addr_q.push_back(a);
                    exp_data_q.push_back(data_of(a));
                end
                issued_total = 0; xfer_total = 0; xfer_lag = 0; stall_model = '0;
                log_rd.delete();
                log_word.delete();
                start_cyc = cyc;
                if (exp_num == 0) done_next = 1;
            end
            if (was_done) begin
                done_next = 0;
                model_busy = 0;
                done_seen++;
                done_cyc = cyc;
                chk("done_addr_all_issued", DW'(exp_addr_q.size()), DW'(0));
            end
            if (last_xfer) done_next = 1;
        end
    end

    task automatic start_drain(input logic [AW-1:0] b, input logic [AW-1:0] n);
        @(posedge clk); #1;
        base_addr = b; num_words = n; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #2 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic wait_idle(input int budget, input string nm);
        int n;
        n = 0;
        while ((model_busy || done_next) && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        if (model_busy || done_next) begin
            fail({nm, "_timeout"});
            do_reset();
        end
        repeat (2) @(posedge clk);
    endtask

    task automatic check_zero_outputs(input string nm);
        chk({nm, "_busy"}, DW'(busy), '0);
        chk({nm, "_done"}, DW'(done), '0);
        chk({nm, "_rd_en"}, DW'(uram_rd_en), '0);
        chk({nm, "_rd_addr"}, DW'(uram_rd_addr), '0);
        chk({nm, "_m_valid"}, DW'(m_valid), '0);
        chk({nm, "_m_last"}, DW'(m_last), '0);
        chk({nm, "_m_data"}, m_data, '0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, n, lim;
        logic [AW-1:0] b;
        repeat (3) @(posedge clk);
        #1 check_zero_outputs("reset");
        @(posedge clk); #1 rst = 1'b1;

        // Basic drain, full-rate ready
        ready_mode = 0;
        d0 = done_seen;
        start_drain(23'h10, 23'd5);
        wait_idle(200, "basic");
        chk("basic_rd_count", DW'(log_rd.size()), DW'(5));
        chk("basic_word_count", DW'(log_word.size()), DW'(5));
        if (log_rd.size() == 5) begin
            chk("basic_rd_first", DW'(log_rd[0]), DW'(23'h10));
            chk("basic_rd_final", DW'(log_rd[4]), DW'(23'h14));
        end
        chk("basic_last_word", DW'(last_word), DW'(23'h14));
        chk("basic_done_pulses", DW'(done_seen - d0), DW'(1));
        chk("basic_throughput", DW'(done_cyc - start_cyc <= 5 + RD_LAT + 4), DW'(1));

        // Backpressure
        ready_mode = 1;
        start_drain(23'h1000, 23'd32);
        wait_idle(2000, "bp");
        chk("bp_word_count", DW'(log_word.size()), DW'(32));
        if (log_word.size() == 32) begin
            chk("bp_first", DW'(log_word[0]), DW'(23'h1000));
            chk("bp_final", DW'(log_word[31]), DW'(23'h101F));
        end

        // Address wrap
        ready_mode = 0;
        start_drain(23'h7FFFFE, 23'd4);
        wait_idle(200, "wrap");
        chk("wrap_rd_count", DW'(log_rd.size()), DW'(4));
        if (log_rd.size() == 4) begin
            chk("wrap_rd0", DW'(log_rd[0]), DW'(23'h7FFFFE));
            chk("wrap_rd1", DW'(log_rd[1]), DW'(23'h7FFFFF));
            chk("wrap_rd2", DW'(log_rd[2]), DW'(23'h0));
            chk("wrap_rd3", DW'(log_rd[3]), DW'(23'h1));
        end

        // Zero words
        d0 = done_seen;
        start_drain(23'h55, 23'd0);
        wait_idle(50, "zero");
        chk("zero_done_pulses", DW'(done_seen - d0), DW'(1));
        chk("zero_no_reads", DW'(log_rd.size()), DW'(0));
        chk("zero_done_latency", DW'(done_cyc - start_cyc >= 1 && done_cyc - start_cyc <= 2), DW'(1));

        // Start while busy is ignored
        ready_mode = 1;
        d0 = done_seen;
        start_drain(23'h100, 23'd6);
        repeat (3) @(posedge clk);
        start_drain(23'h999, 23'd3);
        wait_idle(500, "ignore");
        chk("ignore_word_count", DW'(log_word.size()), DW'(6));
        chk("ignore_last_word", DW'(last_word), DW'(23'h105));
        chk("ignore_done_pulses", DW'(done_seen - d0), DW'(1));

        // Random drains
        for (int k = 0; k < 4; k++) begin
            ready_mode = k % 2;
            b = AW'($urandom);
            n = $urandom_range(1, 40);
            start_drain(b, AW'(n));
            wait_idle(n * 30 + 100, "rand");
            chk("rand_word_count", DW'(log_word.size()), DW'(n));
        end

        // Reset mid-drain
        ready_mode = 0;
        start_drain(23'h200, 23'd16);
        lim = 0;
        while (xfer_total < 3 && lim < 200) begin
            @(negedge clk); #1;
            lim++;
        end
        if (xfer_total < 3) fail("midreset_wait_timeout");
        rst = 1'b0;
        #1 check_zero_outputs("midreset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        start_drain(23'h40, 23'd2);
        wait_idle(200, "after_reset");
        chk("after_reset_rd_count", DW'(log_rd.size()), DW'(2));
        chk("after_reset_word_count", DW'(log_word.size()), DW'(2));
        if (log_rd.size() == 2) begin
            chk("after_reset_rd0", DW'(log_rd[0]), DW'(23'h40));
            chk("after_reset_rd1", DW'(log_rd[1]), DW'(23'h41));
        end
        chk("after_reset_last_word", DW'(last_word), DW'(23'h41));

`ifdef URAM_DRAIN_STALL_CNT_EN
        ready_mode = 2;
        start_drain(23'h300, 23'd4);
        lim = 0;
        while (!m_valid && lim < 50) begin
            @(negedge clk); #1;
            lim++;
        end
        if (!m_valid) fail("stall_valid_timeout");
        repeat (9) @(negedge clk);
        ready_mode = 0;
        wait_idle(200, "stall");
        chk("stall_cnt_held", DW'(stall_cnt), DW'(10));
        start_drain(23'h310, 23'd1);
        chk("stall_cnt_cleared", DW'(stall_cnt), DW'(0));
        wait_idle(200, "stall2");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
